pipeline_loader_ctrl: RTL
=========================

PIPELINE_LOADER_CTRL -- requirements
Module: pipeline_loader_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, instruction/address width.
REQ-002 SHALL have parameter INST_BASE, default 32'h0000_0000, address of first loaded instruction.
REQ-003 SHALL have parameter RST_CYCLES, default 2, cycles o_pipe_rst_n is held low per pipeline reset.
REQ-004 SHALL have port clk  input  1  single clock, rising edge; no other clock is used.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_rx_data  input  8  command/program byte.
REQ-007 SHALL have port i_rx_valid  input  1  byte present on i_rx_data.
REQ-008 SHALL have port o_rx_ready  output  1  byte accepted when valid&ready at clk edge.
REQ-009 SHALL have port i_end_program  input  1  pipeline retired HALT opcode (6'b111111).
REQ-010 SHALL have ports o_pipe_rst_n/o_we_IF/o_halt  output  1 each  pipeline reset, IF-memory write enable, pipeline freeze.
REQ-011 SHALL have ports o_instruction_data/o_inst_addr  output  NB_DATA each  IF-memory write data/address.
REQ-012 SHALL have ports o_cycle_count  output  NB_DATA  executed cycles; o_state  output  3  FSM encoding; o_done  output  1  one-cycle pulse at run completion.

Function
REQ-013 SHALL implement states IDLE(0), LOAD_CNT(1), LOAD_WORD(2), WRITE(3), PRST(4), RUN(5), STEP(6), DONE(7).
REQ-014 IDLE: accepted byte 'L'(0x4C)->LOAD_CNT; 'C'(0x43)->PRST, then RUN; 'S'(0x53)->STEP; 'R'(0x52)->PRST, then IDLE; any other byte discarded, stay IDLE.
REQ-015 LOAD_CNT: accepted byte = word count N; N=0 SHALL return to IDLE with no writes.
REQ-016 LOAD_WORD: SHALL assemble 4 accepted bytes MSB first into one NB_DATA word, then go to WRITE.
REQ-017 WRITE: SHALL assert o_we_IF for exactly one cycle with o_inst_addr = INST_BASE + 4*k (k = 0..N-1), o_rx_ready low; after word N-1 go to PRST then IDLE, else back to LOAD_WORD.
REQ-018 Word address SHALL wrap modulo 2^NB_DATA; no overflow flag.
REQ-019 PRST: o_pipe_rst_n low for exactly RST_CYCLES cycles, o_halt high, then transition to the pending target.
REQ-020 RUN: o_halt low, o_cycle_count +1 per cycle; on i_end_program -> DONE.
REQ-021 STEP: o_halt low for exactly one cycle, o_cycle_count +1, then IDLE; i_end_program during that cycle -> DONE.
REQ-022 DONE: o_done high one cycle, o_halt high, then IDLE; o_cycle_count retained until next 'C' or 'R' (cleared on PRST entry), not cleared by 'S' or 'L'.
REQ-023 o_rx_ready SHALL be high only in IDLE, LOAD_CNT, LOAD_WORD; low in all other states, so bytes arriving during RUN are held off.
REQ-024 o_halt SHALL be high in every state except RUN and the single STEP cycle.
REQ-025 o_we_IF SHALL never be high outside WRITE; o_we_IF and o_pipe_rst_n low SHALL never coincide.
REQ-026 i_end_program outside RUN/STEP SHALL be ignored.
REQ-027 o_cycle_count SHALL saturate at all-ones.

Reset
REQ-028 On i_rst_n low, asynchronously: state IDLE, o_pipe_rst_n 0, o_halt 1, o_we_IF 0, o_rx_ready 0, o_done 0, o_instruction_data 0, o_inst_addr INST_BASE, o_cycle_count 0, byte/word counters 0.
REQ-029 First cycle after i_rst_n release: o_pipe_rst_n 1, o_rx_ready 1; reset mid-load or mid-run SHALL discard partial words and counts.

Structure
REQ-030 State encodings and command byte constants SHALL live in shared package pipeline_ctrl_pkg.
REQ-031 One sub-module, byte_word_assembler (4-byte MSB-first shift register with byte counter and word-valid pulse), SHALL be instantiated; all else is in pipeline_loader_ctrl.

Verification
REQ-032 'L',0x02, bytes 20 00 00 0F 28 00 00 10 -> two o_we_IF pulses: addr 0x0 data 0x2000000F, addr 0x4 data 0x28000010; then o_pipe_rst_n low 2 cycles; state IDLE.
REQ-033 'L',0x00 -> no o_we_IF, back to IDLE next cycle.
REQ-034 'C', i_end_program asserted 10 cycles after o_halt drops -> o_cycle_count=10, one o_done pulse, o_halt high.
REQ-035 'S' three times -> o_halt low exactly 3 single cycles, o_cycle_count=3.
REQ-036 i_rst_n low after 2 of 4 word bytes, then 'L',0x01, 4 bytes AA BB CC DD -> single write data 0xAABBCCDD addr INST_BASE.
REQ-037 i_rx_valid held high with 0x43 during RUN -> o_rx_ready 0, byte consumed only after DONE.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline loader controller: FSM encodings and
// the single-byte command set understood while idle.
package pipeline_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_CNT  = 3'd1;
  localparam logic [2:0] ST_LOAD_WORD = 3'd2;
  localparam logic [2:0] ST_WRITE     = 3'd3;
  localparam logic [2:0] ST_PRST      = 3'd4;
  localparam logic [2:0] ST_RUN       = 3'd5;
  localparam logic [2:0] ST_STEP      = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'

  // States in which the byte stream may be consumed.
  function automatic logic is_rx_state(input logic [2:0] s);
    return (s == ST_IDLE) || (s == ST_LOAD_CNT) || (s == ST_LOAD_WORD);
  endfunction

  // States in which the pipeline is allowed to advance.
  function automatic logic is_exec_state(input logic [2:0] s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Collects four bytes MSB first; the fourth byte completes the word in the
// same cycle it is presented, so the caller can latch it without a bubble.
module byte_word_assembler #(
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               clear_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  output logic [NB_DATA-1:0] word_o,
  output logic               word_valid_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  assign word_o       = NB_DATA'({shift_q, byte_i});
  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_loader_ctrl.sv
// Byte-command controller that loads a program into IF memory, pulses the
// pipeline reset, and runs/steps the pipeline while counting cycles.
module pipeline_loader_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int                 NB_DATA    = 32,
  parameter logic [NB_DATA-1:0] INST_BASE  = 32'h0000_0000,
  parameter int                 RST_CYCLES = 2
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  input  logic               i_end_program,
  output logic               o_pipe_rst_n,
  output logic               o_we_IF,
  output logic               o_halt,
  output logic [NB_DATA-1:0] o_instruction_data,
  output logic [NB_DATA-1:0] o_inst_addr,
  output logic [NB_DATA-1:0] o_cycle_count,
  output logic [2:0]         o_state,
  output logic               o_done
);

  localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  logic [2:0]         state_q, state_d;
  logic [2:0]         target_q, target_d;
  logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [7:0]         words_left_q, words_left_d;
  logic [NB_DATA-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_DATA-1:0] cycle_q, cycle_d;
  logic               live_q;

  logic               rx_accept;
  logic               asm_clear;
  logic               asm_byte_valid;
  logic [NB_DATA-1:0] asm_word;
  logic               asm_word_valid;
  logic [NB_DATA-1:0] cycle_inc;

  // live_q keeps the handshake and pipeline reset asserted until the first
  // clock edge after i_rst_n is released.
  assign o_rx_ready   = live_q && is_rx_state(state_q);
  assign o_pipe_rst_n = live_q && (state_q != ST_PRST);
  assign o_halt       = !(live_q && is_exec_state(state_q));
  assign o_we_IF      = (state_q == ST_WRITE);
  assign o_done       = (state_q == ST_DONE);
  assign o_state      = state_q;
  assign o_instruction_data = data_q;
  assign o_inst_addr        = addr_q;
  assign o_cycle_count      = cycle_q;

  assign rx_accept      = i_rx_valid && o_rx_ready;
  assign asm_clear      = (state_q != ST_LOAD_WORD);
  assign asm_byte_valid = rx_accept && (state_q == ST_LOAD_WORD);
  assign cycle_inc      = (&cycle_q) ? cycle_q : cycle_q + NB_DATA'(1);

  byte_word_assembler #(
    .NB_DATA(NB_DATA)
  ) u_assembler (
    .clk         (clk),
    .rst_n_i     (i_rst_n),
    .clear_i     (asm_clear),
    .byte_i      (i_rx_data),
    .byte_valid_i(asm_byte_valid),
    .word_o      (asm_word),
    .word_valid_o(asm_word_valid)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    rst_cnt_d    = rst_cnt_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cycle_d      = cycle_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_accept) begin
          case (i_rx_data)
            CMD_LOAD:  state_d = ST_LOAD_CNT;
            CMD_CONT: begin
              state_d  = ST_PRST;
              target_d = ST_RUN;
            end
            CMD_STEP:  state_d = ST_STEP;
            CMD_RESET: begin
              state_d  = ST_PRST;
              target_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_CNT: begin
        if (rx_accept) begin
          if (i_rx_data == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            words_left_d = i_rx_data;
            addr_d       = INST_BASE;
            state_d      = ST_LOAD_WORD;
          end
        end
      end
      ST_LOAD_WORD: begin
        if (asm_word_valid) begin
          data_d  = asm_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Address advances on leaving WRITE so o_inst_addr is stable for the pulse.
        addr_d = addr_q + NB_DATA'(4);
        if (words_left_q == 8'd1) begin
          words_left_d = '0;
          state_d      = ST_PRST;
          target_d     = ST_IDLE;
        end else begin
          words_left_d = words_left_q - 8'd1;
          state_d      = ST_LOAD_WORD;
        end
      end
      ST_PRST: begin
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          state_d   = target_q;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      ST_RUN: begin
        cycle_d = cycle_inc;
        if (i_end_program) state_d = ST_DONE;
      end
      ST_STEP: begin
        cycle_d = cycle_inc;
        state_d = i_end_program ? ST_DONE : ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Only the 'C'/'R' commands clear the count; the post-load reset keeps it.
    if ((state_q == ST_IDLE) && (state_d == ST_PRST)) begin
      cycle_d   = '0;
      rst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      target_q     <= ST_IDLE;
      rst_cnt_q    <= '0;
      words_left_q <= '0;
      addr_q       <= INST_BASE;
      data_q       <= '0;
      cycle_q      <= '0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      rst_cnt_q    <= rst_cnt_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cycle_q      <= cycle_d;
      live_q       <= 1'b1;
    end
  end

endmodule
